// File: rtl/cic_pkg.sv
// cic_pkg: shared types for the CIC decimator sequencer.
// Sequencer states and the decimated-sample width.
package cic_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/cic_ctrl_if.sv
// cic_ctrl_if: decimated-sample stream from the sequencer
// to the downstream audio consumer (valid/ready).
interface cic_ctrl_if
  import cic_pkg::*;
#(
  parameter int W = SAMPLE_W
);

  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/cic_ctrl_fifo.sv
// cic_ctrl_fifo: 2-entry sample buffer with flush.
// A push on a full buffer succeeds only alongside a pop.
module cic_ctrl_fifo
  import cic_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/cic_ctrl.sv
// cic_ctrl: PDM bit-clock divider, CIC strobe sequencer and
// warm-up discard in front of a 2-deep output buffer.
module cic_ctrl
  import cic_pkg::*;
#(
  parameter int CLKDIV     = 4,
  parameter int DECIM      = 8,
  parameter int SETTLE_OUT = 2,
  parameter int FLUSH_CYC  = 4,
  parameter int CIC_LAT    = 1,
  parameter int W          = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic         pdm_clk,
  input  logic         pdm_din,
  output logic         cic_reset,
  output logic         cic_din,
  output logic         cic_ce,
  input  logic [W-1:0] cic_val,
  cic_ctrl_if.master   aud,
  output logic         overrun,
  output logic [1:0]   state
);

  localparam int DIVW = $clog2(CLKDIV);
  localparam int BITW = $clog2(DECIM);
  localparam int FLW  =
    (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC);
  localparam int DSW  =
    (SETTLE_OUT < 2) ? 1 : $clog2(SETTLE_OUT + 1);

  state_e             state_q, state_d;
  logic [FLW-1:0]     fl_q, fl_d;
  logic [DIVW-1:0]    div_q, div_d;
  logic [BITW-1:0]    bit_q, bit_d;
  logic [DSW-1:0]     ds_q, ds_d;
  logic [CIC_LAT-1:0] dl_q, dl_d;
  logic               din_q, din_d;
  logic               ce_q, ce_d;
  logic               ovr_q, ovr_d;

  logic run, active, strobe, frame_end;
  logic capture, push, pop, drop;
  logic fifo_full, fifo_empty, fifo_flush;

  assign active = (state_q == ST_SETTLE) ||
                  (state_q == ST_RUN);
  assign run       = enable && active;
  assign strobe    = run &&
                     (div_q == DIVW'(CLKDIV - 1));
  assign frame_end = ce_q &&
                     (bit_q == BITW'(DECIM - 1));
  assign capture   = run && dl_q[CIC_LAT-1];
  assign push      = capture && (state_q == ST_RUN);
  assign pop       = aud.out_valid && aud.out_ready;
  assign drop      = push && fifo_full && !pop;
  assign fifo_flush = !enable || (state_q == ST_IDLE);

  assign pdm_clk   = active &&
                     (div_q < DIVW'(CLKDIV / 2));
  assign cic_reset = (state_q == ST_IDLE) ||
                     (state_q == ST_FLUSH);
  assign cic_din   = din_q;
  assign cic_ce    = ce_q;
  assign overrun   = ovr_q;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    fl_d    = '0;
    ds_d    = ds_q;
    ovr_d   = ovr_q;
    if (!enable) begin
      state_d = ST_IDLE;
      ds_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FLUSH;
          ds_d    = '0;
          ovr_d   = 1'b0;
        end
        ST_FLUSH: begin
          if (fl_q == FLW'(FLUSH_CYC - 1)) begin
            state_d = ST_SETTLE;
          end else begin
            fl_d = fl_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (SETTLE_OUT == 0) begin
            state_d = ST_RUN;
          end else if (capture) begin
            ds_d = ds_q + 1'b1;
            if (ds_q == DSW'(SETTLE_OUT - 1)) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (drop) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Leaving SETTLE/RUN zeroes the divider and kills queued strobes.
  always_comb begin
    div_d = '0;
    bit_d = '0;
    din_d = 1'b0;
    ce_d  = 1'b0;
    dl_d  = '0;
    if (run) begin
      div_d = strobe ? '0 : div_q + 1'b1;
      din_d = strobe ? pdm_din : din_q;
      ce_d  = strobe;
      bit_d = bit_q;
      if (ce_q) begin
        bit_d = frame_end ? '0 : bit_q + 1'b1;
      end
      dl_d[0] = frame_end;
      for (int i = 1; i < CIC_LAT; i++) begin
        dl_d[i] = dl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fl_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ds_q    <= '0;
      dl_q    <= '0;
      din_q   <= 1'b0;
      ce_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ds_q    <= ds_d;
      dl_q    <= dl_d;
      din_q   <= din_d;
      ce_q    <= ce_d;
      ovr_q   <= ovr_d;
    end
  end

  cic_ctrl_fifo #(
    .W(W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (push),
    .pop   (pop),
    .din   (cic_val),
    .head  (aud.out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign aud.out_valid = !fifo_empty;

endmodule

// File: tb/tb_cic_ctrl.sv
// tb_cic_ctrl: stub CIC plus output scoreboard for cic_ctrl,
// with cycle-exact checks of the sequencer timing.
module tb_cic_ctrl;
  import cic_pkg::*;

  localparam int CLKDIV     = 4;
  localparam int DECIM      = 8;
  localparam int SETTLE_OUT = 2;
  localparam int FLUSH_CYC  = 4;
  localparam int CIC_LAT    = 1;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b0;
  logic       pdm_din = 1'b0;
  logic       pdm_clk, cic_reset, cic_din, cic_ce;
  logic       overrun;
  logic [1:0] st;
  sample_t    cic_val = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  cic_ctrl_if #(.W(SAMPLE_W)) aif ();

  cic_ctrl #(
    .CLKDIV     (CLKDIV),
    .DECIM      (DECIM),
    .SETTLE_OUT (SETTLE_OUT),
    .FLUSH_CYC  (FLUSH_CYC),
    .CIC_LAT    (CIC_LAT),
    .W          (SAMPLE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pdm_clk   (pdm_clk),
    .pdm_din   (pdm_din),
    .cic_reset (cic_reset),
    .cic_din   (cic_din),
    .cic_ce    (cic_ce),
    .cic_val   (cic_val),
    .aud       (aif),
    .overrun   (overrun),
    .state     (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  function automatic sample_t fval(input int n);
    return 24'hA50000 + 24'(n) * 24'h010203;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Stub CIC and scoreboard, evaluated 1 unit after each negedge.
  sample_t     exp_q[$];
  logic        exp_ovr = 1'b0;
  logic        prev_en = 1'b0;
  logic [31:0] pend    = '0;
  int          ce_cnt  = 0;
  int          frm_no  = 0;
  int          gval    = 0;

  initial begin : stub_sb
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        exp_ovr = 1'b0;
        prev_en = 1'b0;
        pend    = '0;
        ce_cnt  = 0;
        frm_no  = 0;
        cic_val = '0;
      end else begin
        check("out_valid", 32'(aif.out_valid),
              32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
          check("out_data", 32'(aif.out_data),
                32'(exp_q[0]));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        if (aif.out_valid && aif.out_ready &&
            exp_q.size() != 0)
          void'(exp_q.pop_front());
        cic_val = sample_t'($urandom);
        if (enable && pend[CIC_LAT-1]) begin
          cic_val = fval(gval);
          if (frm_no >= SETTLE_OUT) begin
            if (exp_q.size() < 2) exp_q.push_back(fval(gval));
            else exp_ovr = 1'b1;
          end
          gval++;
          frm_no++;
        end
        pend = pend << 1;
        if (enable && cic_ce) begin
          ce_cnt++;
          if (ce_cnt == DECIM) begin
            ce_cnt  = 0;
            pend[0] = 1'b1;
          end
        end
        if (!enable) begin
          exp_q.delete();
          pend   = '0;
          ce_cnt = 0;
          frm_no = 0;
        end else if (!prev_en) begin
          exp_ovr = 1'b0;
        end
        prev_en = enable;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: run did not complete @cyc %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    logic [7:0] pat;
    pat = 8'b0100_1101;
    aif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    at_cyc(1);
    check("rst_state", 32'(st), 32'd0);
    check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check("rst_cic_reset", 32'(cic_reset), 32'd1);
    check("rst_cic_din", 32'(cic_din), 32'd0);
    check("rst_cic_ce", 32'(cic_ce), 32'd0);
    check("rst_data", 32'(aif.out_data), 32'd0);

    at_cyc(10);
    enable        = 1'b1;
    aif.out_ready = 1'b1;
    at_cyc(11);
    check("flush_state", 32'(st), 32'd1);
    check("flush_rst", 32'(cic_reset), 32'd1);
    at_cyc(14);
    check("flush_end_state", 32'(st), 32'd1);
    check("flush_end_rst", 32'(cic_reset), 32'd1);
    check("flush_pdm_clk", 32'(pdm_clk), 32'd0);
    at_cyc(15);
    check("settle_state", 32'(st), 32'd2);
    check("settle_rst", 32'(cic_reset), 32'd0);

    for (int k = 0; k < 8; k++) begin
      at_cyc(15 + 4 * k);
      pdm_din = pat[k];
      check("pdm_hi", 32'(pdm_clk), 32'd1);
      at_cyc(18 + 4 * k);
      check("pdm_lo", 32'(pdm_clk), 32'd0);
      check("ce_idle", 32'(cic_ce), 32'd0);
      at_cyc(19 + 4 * k);
      check("ce_pulse", 32'(cic_ce), 32'd1);
      check("cic_din", 32'(cic_din), 32'(pat[k]));
    end

    at_cyc(79);
    check("still_settle", 32'(st), 32'd2);
    at_cyc(81);
    check("run_state", 32'(st), 32'd3);
    at_cyc(112);
    check("first_not_yet", 32'(aif.out_valid), 32'd0);
    at_cyc(113);
    check("first_valid", 32'(aif.out_valid), 32'd1);
    check("first_data", 32'(aif.out_data), 32'(fval(2)));
    at_cyc(144);
    check("gap_valid", 32'(aif.out_valid), 32'd0);
    at_cyc(145);
    check("second_data", 32'(aif.out_data), 32'(fval(3)));

    at_cyc(146);
    aif.out_ready = 1'b0;
    at_cyc(240);
    aif.out_ready = 1'b1;
    check("full_head", 32'(aif.out_data), 32'(fval(4)));
    at_cyc(241);
    check("full_pp_ovr", 32'(overrun), 32'd0);
    check("full_pp_d1", 32'(aif.out_data), 32'(fval(5)));
    at_cyc(242);
    check("full_pp_d2", 32'(aif.out_data), 32'(fval(6)));
    at_cyc(243);
    check("drained", 32'(aif.out_valid), 32'd0);
    aif.out_ready = 1'b0;

    at_cyc(337);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_head", 32'(aif.out_data), 32'(fval(7)));
    at_cyc(340);
    aif.out_ready = 1'b1;
    check("ovr_pop1", 32'(aif.out_data), 32'(fval(7)));
    at_cyc(341);
    check("ovr_pop2", 32'(aif.out_data), 32'(fval(8)));
    at_cyc(342);
    check("ovr_empty", 32'(aif.out_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    aif.out_ready = 1'b0;

    at_cyc(369);
    check("pre_dis_data", 32'(aif.out_data), 32'(fval(10)));
    at_cyc(380);
    enable = 1'b0;
    at_cyc(381);
    check("dis_state", 32'(st), 32'd0);
    check("dis_valid", 32'(aif.out_valid), 32'd0);
    check("dis_rst", 32'(cic_reset), 32'd1);
    check("dis_pdm_clk", 32'(pdm_clk), 32'd0);
    check("dis_ovr_held", 32'(overrun), 32'd1);

    at_cyc(390);
    enable = 1'b1;
    at_cyc(391);
    check("re_state", 32'(st), 32'd1);
    check("re_ovr_clr", 32'(overrun), 32'd0);
    at_cyc(395);
    check("re_settle", 32'(st), 32'd2);
    at_cyc(460);
    check("re_still_settle", 32'(st), 32'd2);
    at_cyc(461);
    check("re_run", 32'(st), 32'd3);
    at_cyc(493);
    check("re_valid", 32'(aif.out_valid), 32'd1);
    check("re_data", 32'(aif.out_data), 32'(fval(13)));
    aif.out_ready = 1'b1;
    at_cyc(496);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cic_ctrl.md
Name: cic_ctrl

Overview:
- Sequencer for the CIC decimator: divides clk into the PDM bit clock, samples the microphone bit stream and feeds it to the CIC with a one-cycle advance enable.
- Holds the CIC in reset while disabled and discards warm-up outputs after enable.
- Captures each decimated 24-bit result into a 2-entry output buffer with a valid/ready handshake.
- Sits between the PDM pad and the CIC on one side and the downstream audio consumer on the other.

Parameters:
- CLKDIV, 4: clk cycles per PDM bit; even, at least 2.
- DECIM, 8: PDM bits per CIC output sample; at least 2.
- SETTLE_OUT, 2: decimated outputs discarded after each enable.
- FLUSH_CYC, 4: clk cycles cic_reset is held after enable rises.
- CIC_LAT, 1: clk cycles from the last cic_ce of a decimation frame to valid cic_val; at least 1.
- W, 24: sample width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run request (level)
- pdm_clk  out  1  bit clock to microphone
- pdm_din  in  1  microphone data
- cic_reset  out  1  reset to CIC
- cic_din  out  1  registered PDM bit to CIC
- cic_ce  out  1  one-cycle CIC advance strobe
- cic_val  in  W  CIC decimated result
- out_data  out  W  head of output buffer
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer accepts
- overrun  out  1  sticky: sample dropped on full buffer
- state  out  2  0 IDLE, 1 FLUSH, 2 SETTLE, 3 RUN

Behaviour:
- Reset values:
  - state=IDLE, pdm_clk=0, cic_reset=1, cic_din=0, cic_ce=0.
  - out_valid=0, out_data=0, overrun=0.
  - All counters 0.
- IDLE:
  - Counters cleared, buffer emptied, pdm_clk=0, cic_reset=1.
  - enable=1 moves to FLUSH next cycle and clears overrun.
- FLUSH:
  - cic_reset=1 for exactly FLUSH_CYC cycles, then SETTLE.
  - The divider starts in the first SETTLE cycle.
- Divider:
  - div counts 0..CLKDIV-1 in SETTLE and RUN.
  - pdm_clk=1 while div<CLKDIV/2, else 0.
- Bit strobe (div==CLKDIV-1):
  - Register cic_din<=pdm_din.
  - Pulse cic_ce in the following cycle.
  - bit counter increments per cic_ce, wrapping at DECIM-1.
- Frame end:
  - The cic_ce with bit counter==DECIM-1 ends a frame.
  - cic_val is sampled exactly CIC_LAT cycles later, via a CIC_LAT-deep strobe delay line.
  - In SETTLE the sample is discarded and the discard counter increments; after SETTLE_OUT discards the FSM moves to RUN, and the next frame is the first kept.
  - SETTLE_OUT=0 means SETTLE ends after zero frames.
- Buffer (RUN only): 2-entry FIFO.
  - Push on capture; pop when out_valid && out_ready.
  - out_data is the head entry, valid the same cycle it becomes head.
  - Push and pop in the same cycle on a full buffer: both succeed, no overrun.
  - Push on a full buffer without pop: the new sample is dropped and overrun is set.
  - Push on empty: out_valid=1 the next cycle.
- Disable:
  - enable=0 in any state moves to IDLE next cycle.
  - Buffer flushed, pending delay-line strobes cancelled, cic_reset reasserted.
  - overrun is held until the next enable rise.
- Reset mid-operation: all state returns to reset values next cycle regardless of enable.
- No arithmetic is applied to samples; cic_val is passed through bit-exact.

Decomposition:
- Shared package cic_pkg:
  - state enum (IDLE/FLUSH/SETTLE/RUN, 2 bits).
  - SAMPLE_W=24 constant.
  - sample_t typedef.
- One natural sub-module: cic_ctrl_fifo, a 2-entry W-bit FIFO with push, pop, full, empty and head outputs. The FSM, divider and strobe logic stay in cic_ctrl.

Test Plan:
1. Reset, then enable=1 at cycle 10 -> state goes 1 at cycle 11, 2 at cycle 15; cic_reset=1 until cycle 15. pdm_clk has period 4 with 50% duty, first high at cycle 15.
2. pdm_din=1,0,1,1,... held per bit -> cic_din matches each bit; cic_ce pulses once every 4 clks, one cycle after div==3.
3. Stub CIC returns an incrementing val per frame -> first 2 frames discarded (state 2 -> 3 after the 2nd), third frame's value appears on out_data with out_valid=1 CIC_LAT+1 cycles after its last cic_ce. Consecutive samples are 32 clks apart.
4. out_ready=0 for 3 frames -> 2 entries held in order; third dropped; overrun=1. Then out_ready=1 -> the two held values pop on consecutive cycles.
5. Buffer full with out_ready=1 on the push cycle -> no drop, overrun stays 0.
6. Deassert enable mid-frame, then reassert -> IDLE next cycle, out_valid=0, cic_reset=1; re-enable repeats FLUSH, SETTLE_OUT discards, and overrun clears.
